// File: rtl/gba_bus_master.sv
// CPU MMIO to GBA register-bus bridge: one transaction in flight, byte/half/word
// lane steering, read alignment and a read timeout for unmapped addresses.
module gba_bus_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] OPEN_BUS = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        gb_bus_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [27:0] req_addr,
  input  logic        req_rnw,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [27:0] gb_bus_adr,
  output logic [31:0] gb_bus_din,
  output logic        gb_bus_rnw,
  output logic        gb_bus_ena,
  output logic [1:0]  gb_bus_acc,
  output logic [3:0]  gb_bus_be,
  input  logic [31:0] gb_bus_dout,
  input  logic        gb_bus_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  a_lo;
  logic [1:0]  acc_in;

  function automatic logic [3:0] lane_be(input logic [1:0] acc, input logic [1:0] a);
    case (acc)
      2'd0:    lane_be = 4'b0001 << a;
      2'd1:    lane_be = a[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] rep_wdata(input logic [1:0] acc, input logic [31:0] w);
    case (acc)
      2'd0:    rep_wdata = {4{w[7:0]}};
      2'd1:    rep_wdata = {2{w[15:0]}};
      default: rep_wdata = w;
    endcase
  endfunction

  function automatic logic [31:0] align_rdata(input logic [1:0] acc, input logic [1:0] a,
                                              input logic [31:0] d);
    case (acc)
      2'd0:    align_rdata = (d >> {a, 3'b000}) & 32'h0000_00FF;
      2'd1:    align_rdata = (d >> {a[1], 4'b0000}) & 32'h0000_FFFF;
      default: align_rdata = d;
    endcase
  endfunction

  // Size 3 is an alias for word; normalise it once at accept time.
  assign acc_in = (req_size == 2'd3) ? 2'd2 : req_size;

  always_ff @(posedge clk) begin
    if (gb_bus_rst) begin
      state       <= IDLE;
      wait_cnt    <= 16'd0;
      a_lo        <= 2'd0;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 32'd0;
      gb_bus_adr  <= 28'd0;
      gb_bus_din  <= 32'd0;
      gb_bus_rnw  <= 1'b0;
      gb_bus_ena  <= 1'b0;
      gb_bus_acc  <= 2'd0;
      gb_bus_be   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= ISSUE;
            req_ready  <= 1'b0;
            gb_bus_ena <= 1'b1;
            gb_bus_adr <= {2'b00, req_addr[27:2]};
            gb_bus_rnw <= req_rnw;
            gb_bus_acc <= acc_in;
            gb_bus_be  <= lane_be(acc_in, req_addr[1:0]);
            gb_bus_din <= rep_wdata(acc_in, req_wdata);
            a_lo       <= req_addr[1:0];
          end
        end
        ISSUE: begin
          gb_bus_ena <= 1'b0;
          wait_cnt   <= 16'd0;
          if (!gb_bus_rnw) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= 32'd0;
          end else if (gb_bus_done) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= align_rdata(gb_bus_acc, a_lo, gb_bus_dout);
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          // A done arriving on the final counted cycle still wins over the timeout.
          if (gb_bus_done) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= align_rdata(gb_bus_acc, a_lo, gb_bus_dout);
          end else if ((wait_cnt + 16'd1) == TMO) begin
            state       <= RESP;
            rsp_valid   <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_rdata   <= OPEN_BUS;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        RESP: begin
          state       <= IDLE;
          req_ready   <= 1'b1;
          rsp_valid   <= 1'b0;
          rsp_timeout <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gba_bus_master.sv
// Directed bench for gba_bus_master: a transaction-level model predicts bus
// fields, response cycle and read data; a negedge process compares every cycle.
module tb_gba_bus_master;
  localparam int          TO = 4;
  localparam logic [31:0] OB = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rnw;
  logic [27:0] req_addr;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [27:0] gb_bus_adr;
  logic [31:0] gb_bus_din, gb_bus_dout;
  logic        gb_bus_rnw, gb_bus_ena, gb_bus_done;
  logic [1:0]  gb_bus_acc;
  logic [3:0]  gb_bus_be;

  always #5 clk = ~clk;

  gba_bus_master #(.TIMEOUT(TO), .OPEN_BUS(OB)) dut (
    .clk(clk), .gb_bus_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .gb_bus_adr(gb_bus_adr), .gb_bus_din(gb_bus_din), .gb_bus_rnw(gb_bus_rnw),
    .gb_bus_ena(gb_bus_ena), .gb_bus_acc(gb_bus_acc), .gb_bus_be(gb_bus_be),
    .gb_bus_dout(gb_bus_dout), .gb_bus_done(gb_bus_done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model state: expected bus fields and the cycles of ena / response.
  int          exp_ena = -1;
  int          exp_rsp = -1;
  logic [27:0] exp_adr = '0;
  logic [31:0] exp_din = '0;
  logic [31:0] exp_rdata = '0;
  logic [3:0]  exp_be = '0;
  logic [1:0]  exp_acc = '0;
  logic        exp_rnw = 1'b0;
  logic        exp_tmo = 1'b0;
  bit          chk_en = 1'b0;

  int          last_rsp = -1;
  int          last_ena = -1;
  int          prev_ena = -1;
  logic [31:0] last_rdata = '0;
  logic        last_tmo = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ena",       32'(gb_bus_ena), 32'(cyc == exp_ena));
      chk("rsp_valid", 32'(rsp_valid),  32'(cyc == exp_rsp));
      chk("req_ready", 32'(req_ready),  32'(!(cyc >= exp_ena && cyc <= exp_rsp)));
      chk("bus_adr",   32'(gb_bus_adr), 32'(exp_adr));
      chk("bus_din",   gb_bus_din,      exp_din);
      chk("bus_be",    32'(gb_bus_be),  32'(exp_be));
      chk("bus_acc",   32'(gb_bus_acc), 32'(exp_acc));
      chk("bus_rnw",   32'(gb_bus_rnw), 32'(exp_rnw));
      if (cyc == exp_rsp) begin
        chk("rsp_rdata",   rsp_rdata,        exp_rdata);
        chk("rsp_timeout", 32'(rsp_timeout), 32'(exp_tmo));
      end
      if (gb_bus_ena) begin
        prev_ena = last_ena;
        last_ena = cyc;
      end
      if (rsp_valid) begin
        last_rsp   = cyc;
        last_rdata = rsp_rdata;
        last_tmo   = rsp_timeout;
      end
    end
  end

  // Present a request, wait for accept, then load the model's prediction.
  // k = cycles after ena at which done is returned (-1 = never).
  task automatic issue(input logic rnw, input logic [27:0] addr, input logic [1:0] size,
                       input logic [31:0] wdata, input int k, input logic [31:0] dout,
                       input bit hold, output int n);
    int w;
    int a;
    int accm;
    logic [31:0] rd;
    req_valid = 1'b1; req_rnw = rnw; req_addr = addr; req_size = size; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (w >= 20) chk("accept_wait", 32'(req_ready), 32'd1);
    n = cyc;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    a    = int'(addr % 4);
    accm = (size == 2'd3) ? 2 : int'(size);
    exp_adr = 28'(addr / 4);
    exp_acc = 2'(accm);
    exp_rnw = rnw;
    if (accm == 0) begin
      exp_be  = 4'(1 << a);
      exp_din = (wdata & 32'hFF) * 32'h0101_0101;
      rd      = (dout >> (8 * a)) & 32'hFF;
    end else if (accm == 1) begin
      exp_be  = (a >= 2) ? 4'hC : 4'h3;
      exp_din = (wdata & 32'hFFFF) * 32'h0001_0001;
      rd      = (dout >> (16 * (a / 2))) & 32'hFFFF;
    end else begin
      exp_be  = 4'hF;
      exp_din = wdata;
      rd      = dout;
    end
    exp_ena = n + 1;
    if (!rnw) begin
      exp_rsp = n + 2; exp_rdata = 32'd0; exp_tmo = 1'b0;
    end else if (k >= 0 && k <= TO) begin
      exp_rsp = n + 2 + k; exp_rdata = rd; exp_tmo = 1'b0;
    end else begin
      exp_rsp = n + 2 + TO; exp_rdata = OB; exp_tmo = 1'b1;
    end
  endtask

  // Play the endpoint: done pulse k cycles after ena, then run past the response.
  task automatic finish(input int k, input logic [31:0] dout);
    int c;
    c = 0;
    while (((cyc <= exp_rsp) || (k >= 0 && c <= k)) && c < 300) begin
      if (k >= 0 && c == k) begin
        gb_bus_done = 1'b1;
        gb_bus_dout = dout;
      end
      @(posedge clk); #1;
      gb_bus_done = 1'b0;
      gb_bus_dout = 32'hFFFF_FFFF;
      c++;
    end
    if (c >= 300) chk("finish_bound", 32'(c), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n1, n2;
    rst = 1'b1; req_valid = 1'b0; req_rnw = 1'b0; req_addr = '0; req_size = '0;
    req_wdata = '0; gb_bus_done = 1'b0; gb_bus_dout = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp",   32'(rsp_valid), 32'd0);
    chk("rst_tmo",   32'(rsp_timeout), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_ena",   32'(gb_bus_ena), 32'd0);
    @(posedge clk); #1;

    // Write byte
    issue(1'b0, 28'h4000003, 2'd0, 32'h0000_005A, -1, 32'd0, 1'b0, n);
    chk("wb_adr", 32'(gb_bus_adr), 32'h0100_0000);
    chk("wb_be",  32'(gb_bus_be), 32'h8);
    chk("wb_din", gb_bus_din, 32'h5A5A_5A5A);
    finish(-1, 32'd0);
    chk("wb_lat",   32'(last_rsp - n), 32'd2);
    chk("wb_rdata", last_rdata, 32'd0);

    // Read halfword, done 3 cycles after ena
    issue(1'b1, 28'h4000006, 2'd1, 32'd0, 3, 32'hBEEF_1234, 1'b0, n);
    chk("rh_be", 32'(gb_bus_be), 32'hC);
    finish(3, 32'hBEEF_1234);
    chk("rh_lat",   32'(last_rsp - n), 32'd5);
    chk("rh_rdata", last_rdata, 32'h0000_BEEF);
    chk("rh_tmo",   32'(last_tmo), 32'd0);

    // Read word, done in the ena cycle, misaligned address
    issue(1'b1, 28'h4000003, 2'd2, 32'd0, 0, 32'hCAFE_F00D, 1'b0, n);
    chk("rw_be", 32'(gb_bus_be), 32'hF);
    finish(0, 32'hCAFE_F00D);
    chk("rw_lat",   32'(last_rsp - n), 32'd2);
    chk("rw_rdata", last_rdata, 32'hCAFE_F00D);

    // Byte read from lane 2, half read with a[0] set
    issue(1'b1, 28'h0000012, 2'd0, 32'd0, 1, 32'h1122_3344, 1'b0, n);
    finish(1, 32'h1122_3344);
    chk("rb_lat",   32'(last_rsp - n), 32'd3);
    chk("rb_rdata", last_rdata, 32'h0000_0022);
    issue(1'b1, 28'h0000005, 2'd1, 32'd0, 2, 32'h1122_3344, 1'b0, n);
    chk("rh1_be", 32'(gb_bus_be), 32'h3);
    finish(2, 32'h1122_3344);
    chk("rh1_rdata", last_rdata, 32'h0000_3344);

    // Size 3 write is a word; half write on upper lanes
    issue(1'b0, 28'h0000108, 2'd3, 32'h1234_5678, -1, 32'd0, 1'b0, n);
    chk("w3_acc", 32'(gb_bus_acc), 32'd2);
    chk("w3_adr", 32'(gb_bus_adr), 32'h42);
    chk("w3_din", gb_bus_din, 32'h1234_5678);
    finish(-1, 32'd0);
    issue(1'b0, 28'h000000A, 2'd1, 32'hAAAA_5678, -1, 32'd0, 1'b0, n);
    chk("wh_be",  32'(gb_bus_be), 32'hC);
    chk("wh_din", gb_bus_din, 32'h5678_5678);
    finish(-1, 32'd0);

    // Timeout, with a late done one cycle after the response
    issue(1'b1, 28'h4000100, 2'd2, 32'd0, 6, 32'h5555_AAAA, 1'b0, n);
    finish(6, 32'h5555_AAAA);
    chk("to_lat",   32'(last_rsp - n), 32'd6);
    chk("to_flag",  32'(last_tmo), 32'd1);
    chk("to_rdata", last_rdata, 32'h0BAD_F00D);
    repeat (2) begin @(posedge clk); #1; end
    chk("to_late_ignored", 32'(last_rsp - n), 32'd6);

    // Done on the same cycle the counter reaches TIMEOUT is a success
    issue(1'b1, 28'h0000001, 2'd0, 32'd0, TO, 32'hA1B2_C3D4, 1'b0, n);
    finish(TO, 32'hA1B2_C3D4);
    chk("edge_lat",   32'(last_rsp - n), 32'd6);
    chk("edge_tmo",   32'(last_tmo), 32'd0);
    chk("edge_rdata", last_rdata, 32'h0000_00C3);

    // Reset during WAIT aborts without a response
    issue(1'b1, 28'h4000020, 2'd2, 32'd0, -1, 32'd0, 1'b0, n);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    exp_ena = -1; exp_rsp = -1; exp_adr = '0; exp_din = '0; exp_be = '0;
    exp_acc = '0; exp_rnw = 1'b0;
    rst = 1'b0;
    chk("ra_ready", 32'(req_ready), 32'd1);
    chk("ra_adr",   32'(gb_bus_adr), 32'd0);
    chk("ra_be",    32'(gb_bus_be), 32'd0);
    gb_bus_done = 1'b1; gb_bus_dout = 32'h1234_5678;
    @(posedge clk); #1;
    gb_bus_done = 1'b0; gb_bus_dout = 32'hFFFF_FFFF;
    repeat (6) begin @(posedge clk); #1; end
    chk("ra_no_rsp", 32'(last_rsp < n), 32'd1);
    issue(1'b0, 28'h0000000, 2'd0, 32'h0000_0077, -1, 32'd0, 1'b0, n);
    chk("ra_new_din", gb_bus_din, 32'h7777_7777);
    finish(-1, 32'd0);
    chk("ra_new_lat", 32'(last_rsp - n), 32'd2);

    // Back-to-back writes with req_valid held
    issue(1'b0, 28'h0000100, 2'd2, 32'h1111_1111, -1, 32'd0, 1'b1, n1);
    issue(1'b0, 28'h0000104, 2'd2, 32'h2222_2222, -1, 32'd0, 1'b0, n2);
    finish(-1, 32'd0);
    chk("b2b_accept_gap", 32'(n2 - n1), 32'd3);
    chk("b2b_ena_gap",    32'(last_ena - prev_ena), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gba_bus_master.md
# gba_bus_master

Single-initiator bridge that turns CPU-side MMIO requests into transactions on the GBA register bus (`gb_bus_*`) consumed by every register endpoint in the design. Each request is a byte, halfword or word access. The bridge converts the byte address into a word address, byte enables and replicated write data. For reads it waits for `gb_bus_done`, aligns and zero-extends the returned data, and returns a one-cycle response; a timeout guards against unmapped addresses. One transaction is in flight at a time.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum number of cycles to wait for `gb_bus_done` on a read (range 1..65535).
- `OPEN_BUS`, 32'h0000_0000: read data returned on timeout.

Ports:
- `clk`  in  1: single clock; all logic on rising edge.
- `gb_bus_rst`  in  1: synchronous, active-high reset; shared with all bus endpoints.
- `req_valid`  in  1: CPU request present.
- `req_ready`  out  1: bridge can accept; high only in IDLE.
- `req_addr`  in  28: byte address.
- `req_rnw`  in  1: 1 = read, 0 = write.
- `req_size`  in  2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `req_wdata`  in  32: write data, right-aligned.
- `rsp_valid`  out  1: one-cycle response pulse.
- `rsp_rdata`  out  32: aligned, zero-extended read data; 0 for writes.
- `rsp_timeout`  out  1: qualifies `rsp_valid`; read timed out.
- `gb_bus_adr`  out  28: word address = {2'b00, req_addr[27:2]}.
- `gb_bus_din`  out  32: write data to endpoints.
- `gb_bus_rnw`  out  1: 1 = read.
- `gb_bus_ena`  out  1: one-cycle transaction strobe.
- `gb_bus_acc`  out  2: `req_size` as latched (3 is driven as 2).
- `gb_bus_be`  out  4: byte enables.
- `gb_bus_dout`  in  32: read data from the addressed endpoint, valid when `gb_bus_done`.
- `gb_bus_done`  in  1: endpoint read completion.

## Operation
- States:
  - IDLE: `req_ready`=1. `req_valid` latches the request and moves to ISSUE.
  - ISSUE: `gb_bus_ena`=1 for exactly this cycle. A write goes to RESP. A read with `gb_bus_done`=1 captures data and goes to RESP; otherwise it goes to WAIT.
  - WAIT: a read with `gb_bus_done`=1 captures data and goes to RESP. When the wait counter reaches `TIMEOUT`, the bridge goes to RESP with the timeout flag set.
  - RESP: `rsp_valid`=1, then IDLE.
- Byte enables, where a = latched addr[1:0]:
  - Byte: be = 4'b0001 << a.
  - Half: be = a[1] ? 4'b1100 : 4'b0011, with a[0] ignored.
  - Word: be = 4'b1111, with a ignored.
- Write data: the byte is replicated ×4 (wdata[7:0] in every lane), the half is replicated ×2 (wdata[15:0]), and the word is passed unchanged.
- Read data:
  - Byte: rdata = {24'b0, dout >> (8·a)}[7:0].
  - Half: rdata = {16'b0, dout >> (16·a[1])}[15:0].
  - Word: rdata = dout.
- Timeout: `rsp_rdata`=`OPEN_BUS` and `rsp_timeout`=1. A late `gb_bus_done` after the timeout is ignored.
- `gb_bus_adr`, `gb_bus_din`, `gb_bus_rnw`, `gb_bus_acc` and `gb_bus_be` are held from ISSUE until the next accept. Endpoints sample them only under `gb_bus_ena`.
- `gb_bus_done` is ignored in IDLE and RESP.
- `gb_bus_dout` is sampled only in the cycle where `gb_bus_done`=1 in ISSUE or WAIT.

## Timing
- Reset (`gb_bus_rst`=1 at a clock edge) forces:
  - state IDLE and wait counter 0;
  - `req_ready`=1 from the following cycle;
  - `rsp_valid`=0, `rsp_timeout`=0, `rsp_rdata`=0;
  - `gb_bus_ena`=0 and all other `gb_bus_*` outputs 0.
- Reset mid-transaction aborts the transaction without a response. Reset wins over a simultaneous `req_valid`.
- Accept at edge N. `gb_bus_ena` is high in cycle N+1 and is never high in two consecutive cycles.
- Write: `rsp_valid` in cycle N+2. The next accept is possible at edge N+3.
- Read with `gb_bus_done` in the ena cycle: `rsp_valid` in cycle N+2.
- Read with `gb_bus_done` k cycles after ena (1 ≤ k ≤ `TIMEOUT`−1): `rsp_valid` in cycle N+2+k.
- Read with no `gb_bus_done`: the WAIT counter increments once per WAIT cycle. At count `TIMEOUT` the bridge goes to RESP, so `rsp_valid` with `rsp_timeout` appears in cycle N+2+`TIMEOUT`.
- A `gb_bus_done` arriving in the same cycle the counter reaches `TIMEOUT` counts as success and gives no timeout.
- The counter is wide enough (16 bits) that it never wraps.
- Outputs are registered; none depends combinationally on `req_valid`.

## Test plan
- Write byte: addr 0x4000003, size 0, wdata 0x5A. Expect `gb_bus_adr`=0x1000000, be=4'b1000, din=0x5A5A5A5A, ena for one cycle, and `rsp_valid` 2 cycles after accept with rdata 0.
- Read halfword: addr 0x4000006; endpoint returns dout=0xBEEF1234 with done 3 cycles after ena. Expect be=4'b1100, rdata=0x0000BEEF, `rsp_timeout`=0, `rsp_valid` at N+5.
- Read word with done in the ena cycle: dout=0xCAFEF00D. Expect rdata=0xCAFEF00D at N+2. Addr bits [1:0]=2'b11 do not change be (4'b1111).
- Timeout with `TIMEOUT`=4, read with no done. Expect `rsp_valid` at N+6 with `rsp_timeout`=1 and rdata=`OPEN_BUS`. A done pulse at N+7 produces no response.
- Reset asserted while in WAIT, then a done pulse. Expect no `rsp_valid`, `req_ready`=1, and all `gb_bus_*` outputs 0 after reset. A new request issues normally.
- Back-to-back writes with `req_valid` held high: ena pulses separated by exactly 2 idle cycles, and `req_ready` is low during ISSUE and RESP.
